// File: rtl/mvm_pkg.sv
// Shared types and constants for the matrix-vector MAC block.
package mvm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  localparam int SHIFT_BITS = 5;
  localparam int RAM_LAT    = 2;
endpackage

// File: rtl/matrix_vector_mac_if.sv
// RAM-side bus of the matrix-vector MAC: synchronous reads of A and B, writes of RES.
interface matrix_vector_mac_if #(
  parameter int width          = 8,
  parameter int A_depth_bits   = 9,
  parameter int B_depth_bits   = 3,
  parameter int RES_depth_bits = 6
);
  logic                      A_read_en;
  logic [A_depth_bits-1:0]   A_read_address;
  logic [width-1:0]          A_read_data_out;
  logic                      B_read_en;
  logic [B_depth_bits-1:0]   B_read_address;
  logic [width-1:0]          B_read_data_out;
  logic                      RES_write_en;
  logic [RES_depth_bits-1:0] RES_write_address;
  logic [width-1:0]          RES_write_data_in;

  modport master (
    output A_read_en, A_read_address, input A_read_data_out,
    output B_read_en, B_read_address, input B_read_data_out,
    output RES_write_en, RES_write_address, RES_write_data_in
  );

  modport slave (
    input A_read_en, A_read_address, output A_read_data_out,
    input B_read_en, B_read_address, output B_read_data_out,
    input RES_write_en, RES_write_address, RES_write_data_in
  );
endinterface

// File: rtl/mvm_sat_shift.sv
// Combinational right shift of a full-precision sum, clamped to width bits.
module mvm_sat_shift
  import mvm_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int width     = 8
) (
  input  logic [ACC_WIDTH-1:0]  value,
  input  logic [SHIFT_BITS-1:0] shift,
  output logic [width-1:0]      result,
  output logic                  sat
);
  logic [ACC_WIDTH-1:0] shifted;

  always_comb begin
    shifted = value >> shift;
    sat     = |shifted[ACC_WIDTH-1:width];
    result  = sat ? {width{1'b1}} : shifted[width-1:0];
  end
endmodule

// File: rtl/matrix_vector_mac.sv
// RES[i] = sat((sum_j A[i][j]*B[j]) >> shift) over a runtime rows x cols shape.
// One A/B pair issued per cycle; results land RAM_LAT cycles after the last issue of a row.
module matrix_vector_mac
  import mvm_pkg::*;
#(
  parameter int width          = 8,
  parameter int A_depth_bits   = 9,
  parameter int B_depth_bits   = 3,
  parameter int RES_depth_bits = 6,
  parameter int ACC_WIDTH      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Start,
  input  logic [RES_depth_bits:0] cfg_rows,
  input  logic [B_depth_bits:0]   cfg_cols,
  input  logic [SHIFT_BITS-1:0]   cfg_shift,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Cfg_error,
  output logic                    Overflow,
  matrix_vector_mac_if.master     ram
);
  localparam int ROWS_W = RES_depth_bits + 1;
  localparam int COLS_W = B_depth_bits + 1;
  localparam int CMP_W  = ROWS_W + COLS_W + A_depth_bits;
  localparam logic [ROWS_W-1:0] MAX_ROWS  = ROWS_W'(1) << RES_depth_bits;
  localparam logic [COLS_W-1:0] MAX_COLS  = COLS_W'(1) << B_depth_bits;
  localparam logic [CMP_W-1:0]  MAX_ELEMS = CMP_W'(1) << A_depth_bits;

  if (ACC_WIDTH < 2*width + B_depth_bits) begin : g_acc_check
    $error("ACC_WIDTH too narrow to hold a full-precision row sum");
  end

  state_t                    state;
  logic [ROWS_W-1:0]         rows_q;
  logic [COLS_W-1:0]         cols_q;
  logic [SHIFT_BITS-1:0]     shift_q;
  logic                      err_q;
  logic [RES_depth_bits-1:0] row;
  logic [B_depth_bits-1:0]   col;
  logic [A_depth_bits-1:0]   a_addr;
  logic                      last_col;
  logic                      last_row;
  logic                      issue;
  logic                      cfg_bad;
  logic [CMP_W-1:0]          elems;

  logic [RAM_LAT-1:0]        vld;
  logic [RAM_LAT-1:0]        first_p;
  logic [RAM_LAT-1:0]        last_p;
  logic [RES_depth_bits-1:0] row_p [RAM_LAT];
  logic [ACC_WIDTH-1:0]      acc;
  logic [2*width-1:0]        prod;
  logic [ACC_WIDTH-1:0]      sum;
  logic [width-1:0]          sat_res;
  logic                      sat_hit;

  assign last_col = ({1'b0, col} == cols_q - 1'b1);
  assign last_row = ({1'b0, row} == rows_q - 1'b1);
  assign issue    = (state == RUN);
  assign elems    = CMP_W'(cfg_rows) * CMP_W'(cfg_cols);
  assign cfg_bad  = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_rows > MAX_ROWS) ||
                    (cfg_cols > MAX_COLS) || (elems > MAX_ELEMS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      rows_q             <= '0;
      cols_q             <= '0;
      shift_q            <= '0;
      err_q              <= 1'b0;
      row                <= '0;
      col                <= '0;
      a_addr             <= '0;
      Busy               <= 1'b0;
      Done               <= 1'b0;
      Cfg_error          <= 1'b0;
      ram.A_read_en      <= 1'b0;
      ram.A_read_address <= '0;
      ram.B_read_en      <= 1'b0;
      ram.B_read_address <= '0;
    end else begin
      ram.A_read_en <= 1'b0;
      ram.B_read_en <= 1'b0;
      Done          <= 1'b0;
      Cfg_error     <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            rows_q  <= cfg_rows;
            cols_q  <= cfg_cols;
            shift_q <= cfg_shift;
            err_q   <= cfg_bad;
            row     <= '0;
            col     <= '0;
            a_addr  <= '0;
            Busy    <= 1'b1;
            state   <= cfg_bad ? FIN : RUN;
          end
        end
        RUN: begin
          ram.A_read_en      <= 1'b1;
          ram.A_read_address <= a_addr;
          ram.B_read_en      <= 1'b1;
          ram.B_read_address <= col;
          a_addr             <= a_addr + 1'b1;
          // column is the inner loop; A is packed row-major so a_addr just counts
          if (last_col) begin
            col <= '0;
            if (last_row) state <= DRAIN;
            else          row   <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        DRAIN: begin
          if (vld[RAM_LAT-2:0] == '0) state <= FIN;
        end
        FIN: begin
          Done      <= 1'b1;
          Cfg_error <= err_q;
          Busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign prod = ram.A_read_data_out * ram.B_read_data_out;
  assign sum  = (first_p[RAM_LAT-1] ? '0 : acc) + ACC_WIDTH'(prod);

  mvm_sat_shift #(
    .ACC_WIDTH (ACC_WIDTH),
    .width     (width)
  ) u_sat_shift (
    .value  (sum),
    .shift  (shift_q),
    .result (sat_res),
    .sat    (sat_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld                   <= '0;
      first_p               <= '0;
      last_p                <= '0;
      for (int k = 0; k < RAM_LAT; k++) row_p[k] <= '0;
      acc                   <= '0;
      Overflow              <= 1'b0;
      ram.RES_write_en      <= 1'b0;
      ram.RES_write_address <= '0;
      ram.RES_write_data_in <= '0;
    end else begin
      // issue tags travel alongside the RAM read latency
      vld     <= {vld[RAM_LAT-2:0], issue};
      first_p <= {first_p[RAM_LAT-2:0], issue && (col == '0)};
      last_p  <= {last_p[RAM_LAT-2:0], issue && last_col};
      row_p[0] <= row;
      for (int k = 1; k < RAM_LAT; k++) row_p[k] <= row_p[k-1];
      ram.RES_write_en <= 1'b0;
      if (state == IDLE && Start) Overflow <= 1'b0;
      if (vld[RAM_LAT-1]) begin
        acc <= sum;
        if (last_p[RAM_LAT-1]) begin
          ram.RES_write_en      <= 1'b1;
          ram.RES_write_address <= row_p[RAM_LAT-1];
          ram.RES_write_data_in <= sat_res;
          if (sat_hit) Overflow <= 1'b1;
        end
      end
    end
  end
endmodule
